// File: rtl/gan_layer_datapath_if.sv
// rtl/gan_layer_datapath_if.sv - control word, ROM read and output-memory write signals of the GAN layer datapath
interface gan_layer_datapath_if #(
  parameter int DATA_W = 8
);
  logic [9:0]        Ctrl;
  logic [DATA_W-1:0] In_data;
  logic [DATA_W-1:0] W_data;
  logic [DATA_W-1:0] B_data;
  logic [4:0]        Wb_count;
  logic [2:0]        O_count;
  logic              W_rd;
  logic [4:0]        W_addr;
  logic              B_rd;
  logic [2:0]        B_addr;
  logic              Out_we;
  logic [2:0]        Out_addr;
  logic [DATA_W-1:0] Out_data;

  modport master (
    output Ctrl, In_data, W_data, B_data,
    input  Wb_count, O_count, W_rd, W_addr, B_rd, B_addr, Out_we, Out_addr, Out_data
  );

  modport slave (
    input  Ctrl, In_data, W_data, B_data,
    output Wb_count, O_count, W_rd, W_addr, B_rd, B_addr, Out_we, Out_addr, Out_data
  );
endinterface

// File: rtl/gan_layer_datapath.sv
// rtl/gan_layer_datapath.sv - GAN layer datapath: counters, ROM strobes, signed MAC and ReLU-saturated output writes
module gan_layer_datapath #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic                 Clock,
  input  logic                 Reset,
  gan_layer_datapath_if.slave  bus
);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);

  logic load_s, res_reg_all, en_input_reg, en_w_mem, en_b_mem;
  logic en_out_mem, en_wb_count, en_o_count, res_wb_count, res_o_count;

  assign load_s       = bus.Ctrl[9];
  assign res_reg_all  = bus.Ctrl[8];
  assign en_input_reg = bus.Ctrl[7];
  assign en_w_mem     = bus.Ctrl[6];
  assign en_b_mem     = bus.Ctrl[5];
  assign en_out_mem   = bus.Ctrl[4];
  assign en_wb_count  = bus.Ctrl[3];
  assign en_o_count   = bus.Ctrl[2];
  assign res_wb_count = bus.Ctrl[1];
  assign res_o_count  = bus.Ctrl[0];

  logic [4:0] wb_count;
  logic [2:0] o_count;
  logic       w_rd, b_rd;

  logic signed [DATA_W-1:0]   in_reg, a_q;
  logic                       mac_v, bias_v;
  logic signed [ACC_W-1:0]    acc, acc_sum, prod_ext, bias_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]          sat_val;

  logic              out_we;
  logic [2:0]        out_addr;
  logic [DATA_W-1:0] out_data;

  // Clears take priority over the matching enables.
  always_ff @(posedge Clock) begin
    if (!Reset || !res_wb_count) begin
      wb_count <= '0;
    end else if (en_wb_count) begin
      wb_count <= wb_count + 5'd1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset || !res_o_count) begin
      o_count <= '0;
    end else if (en_o_count) begin
      o_count <= o_count + 3'd1;
    end
  end

  assign w_rd = Reset & en_w_mem & res_reg_all;
  assign b_rd = Reset & en_b_mem & res_reg_all;

  assign prod     = a_q * $signed(bus.W_data);
  assign prod_ext = ACC_W'(prod);
  assign bias_ext = ACC_W'($signed(bus.B_data));
  assign acc_sum  = acc + (mac_v ? prod_ext : '0) + (bias_v ? bias_ext : '0);

  // ReLU followed by clamp to the largest positive output code.
  always_comb begin
    sat_val = acc_sum[DATA_W-1:0];
    if (acc_sum[ACC_W-1]) begin
      sat_val = '0;
    end else if (acc_sum > SAT_MAX) begin
      sat_val = SAT_MAX[DATA_W-1:0];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      acc      <= '0;
      in_reg   <= '0;
      a_q      <= '0;
      mac_v    <= 1'b0;
      bias_v   <= 1'b0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
    end else if (!res_reg_all) begin
      acc    <= '0;
      in_reg <= '0;
      a_q    <= '0;
      mac_v  <= 1'b0;
      bias_v <= 1'b0;
      out_we <= 1'b0;
    end else begin
      mac_v  <= w_rd;
      bias_v <= b_rd;
      if (w_rd) begin
        a_q <= in_reg;
      end
      // Load_s=0 feeds the saturated layer result back as the next input.
      if (en_input_reg) begin
        in_reg <= load_s ? $signed(bus.In_data) : $signed(sat_val);
      end
      if (en_out_mem) begin
        out_we   <= 1'b1;
        out_addr <= o_count;
        out_data <= sat_val;
        acc      <= '0;
      end else begin
        out_we <= 1'b0;
        acc    <= acc_sum;
      end
    end
  end

  assign bus.Wb_count = wb_count;
  assign bus.O_count  = o_count;
  assign bus.W_rd     = w_rd;
  assign bus.W_addr   = wb_count;
  assign bus.B_rd     = b_rd;
  assign bus.B_addr   = o_count;
  assign bus.Out_we   = out_we;
  assign bus.Out_addr = out_addr;
  assign bus.Out_data = out_data;
endmodule

// File: tb/tb_gan_layer_datapath.sv
// tb/tb_gan_layer_datapath.sv - self-checking bench for gan_layer_datapath with an output-write scoreboard
module tb_gan_layer_datapath;
  logic Clock = 1'b0;
  logic Reset;
  always #5 Clock = ~Clock;

  gan_layer_datapath_if #(.DATA_W(8)) bus();

  gan_layer_datapath #(.DATA_W(8), .ACC_W(20)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  tests_run    = 0;
  int  tests_failed = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rnd();
    return 8'($urandom);
  endfunction

  task automatic drive(input logic [9:0] c, input logic [7:0] ind, input logic [7:0] wd, input logic [7:0] bd);
    bus.Ctrl    = c;
    bus.In_data = ind;
    bus.W_data  = wd;
    bus.B_data  = bd;
    #1;
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic expect_write(input logic [2:0] a, input logic [7:0] d);
    exp_q.push_back({a, d});
  endtask

  // Every write pulse must match the oldest expected write.
  always @(negedge Clock) begin
    wr_t e;
    if (Reset === 1'b1 && bus.Out_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_we", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check_val("out_addr", bus.Out_addr, e.addr);
        check_val("out_data", bus.Out_data, e.data);
      end
    end
  end

  initial begin
    Reset = 1'b0;
    drive(10'h3FF, rnd(), rnd(), rnd());
    check_val("rst_w_rd", bus.W_rd, 0);
    check_val("rst_b_rd", bus.B_rd, 0);
    tick();
    drive(10'h3FF, rnd(), rnd(), rnd());
    tick();
    check_val("rst_wb_count", bus.Wb_count, 0);
    check_val("rst_o_count", bus.O_count, 0);
    check_val("rst_out_we", bus.Out_we, 0);
    check_val("rst_out_addr", bus.Out_addr, 0);
    check_val("rst_out_data", bus.Out_data, 0);
    check_val("rst_w_rd2", bus.W_rd, 0);
    check_val("rst_b_rd2", bus.B_rd, 0);
    Reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      drive(10'h10B, rnd(), rnd(), rnd());
      check_val("wb_count_run", bus.Wb_count, i);
      tick();
    end
    check_val("wb_count_wrap", bus.Wb_count, 0);
    check_val("o_count_hold", bus.O_count, 0);
    for (int i = 0; i < 3; i++) begin
      drive(10'h10B, rnd(), rnd(), rnd());
      tick();
    end
    check_val("wb_count_3", bus.Wb_count, 3);
    drive(10'h109, rnd(), rnd(), rnd());
    tick();
    check_val("wb_count_clear", bus.Wb_count, 0);
    for (int i = 0; i < 2; i++) begin
      drive(10'h10B, rnd(), rnd(), rnd());
      tick();
    end
    check_val("wb_count_2", bus.Wb_count, 2);

    // MAC 3*2 + 3*(-5), bias 20 landing with the write strobe
    drive(10'h383, 8'd3, rnd(), rnd());
    tick();
    drive(10'h143, rnd(), rnd(), rnd());
    check_val("mac_w_rd", bus.W_rd, 1);
    check_val("mac_w_addr", bus.W_addr, 2);
    tick();
    drive(10'h143, rnd(), 8'd2, rnd());
    tick();
    drive(10'h123, rnd(), 8'hFB, rnd());
    check_val("bias_b_rd", bus.B_rd, 1);
    check_val("bias_b_addr", bus.B_addr, 0);
    check_val("bias_w_rd_off", bus.W_rd, 0);
    tick();
    drive(10'h113, rnd(), rnd(), 8'd20);
    expect_write(3'd0, 8'd11);
    tick();
    check_val("write_we", bus.Out_we, 1);
    drive(10'h113, rnd(), rnd(), rnd());
    expect_write(3'd0, 8'd0);
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();
    check_val("write_pulse_end", bus.Out_we, 0);

    for (int i = 0; i < 9; i++) begin
      drive(10'h107, rnd(), rnd(), rnd());
      check_val("o_count_run", bus.O_count, i % 8);
      tick();
    end
    check_val("o_count_1", bus.O_count, 1);

    // Feedback: in_reg <- sat(5*10)=50, then 50 + 50*1
    drive(10'h383, 8'd5, rnd(), rnd());
    tick();
    drive(10'h143, rnd(), rnd(), rnd());
    tick();
    drive(10'h183, rnd(), 8'd10, rnd());
    tick();
    drive(10'h143, rnd(), rnd(), rnd());
    tick();
    drive(10'h113, rnd(), 8'd1, rnd());
    expect_write(3'd1, 8'd100);
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();

    // 3 x 100 saturates to 127
    drive(10'h383, 8'd100, rnd(), rnd());
    tick();
    drive(10'h143, rnd(), rnd(), rnd());
    tick();
    drive(10'h143, rnd(), 8'd1, rnd());
    tick();
    drive(10'h143, rnd(), 8'd1, rnd());
    tick();
    drive(10'h113, rnd(), 8'd1, rnd());
    expect_write(3'd1, 8'd127);
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();

    // 2 x -2 = -4 clips to 0
    drive(10'h383, 8'd2, rnd(), rnd());
    tick();
    drive(10'h143, rnd(), rnd(), rnd());
    tick();
    drive(10'h113, rnd(), 8'hFE, rnd());
    expect_write(3'd1, 8'd0);
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();

    drive(10'h106, rnd(), rnd(), rnd());
    tick();
    check_val("o_count_clear", bus.O_count, 0);
    check_val("wb_count_kept", bus.Wb_count, 2);

    // Register clear in the landing cycle drops the in-flight product
    drive(10'h143, rnd(), rnd(), rnd());
    tick();
    drive(10'h043, rnd(), 8'd50, rnd());
    check_val("clr_w_rd", bus.W_rd, 0);
    tick();
    check_val("clr_out_we", bus.Out_we, 0);
    check_val("clr_wb_count", bus.Wb_count, 2);
    check_val("clr_o_count", bus.O_count, 0);
    drive(10'h113, rnd(), rnd(), rnd());
    expect_write(3'd0, 8'd0);
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();
    drive(10'h103, rnd(), rnd(), rnd());
    tick();
    check_val("pending_writes", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/gan_layer_datapath.md
# gan_layer_datapath

Datapath responder for the GAN layer sequencer. It consumes the 10-bit control word from the layer control unit and returns the weight/bias counter `Wb_count`. Internally it holds the input register and the counters, drives read strobes to the external weight and bias ROMs, runs a signed multiply-accumulate, and writes ReLU-saturated results to the output memory. It sits between the control unit and the weight ROM, bias ROM and output RAM.

## Interface
- `DATA_W`, default 8: signed width of input, weight, bias and output data.
- `ACC_W`, default 20: signed accumulator width; must be at least 2*DATA_W.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-low reset.
- `Ctrl`  in  10  control word. Bit meanings:
  - 9 `Load_s`, 8 `Res_reg_all`, 7 `En_input_reg`, 6 `En_w_mem`, 5 `En_b_mem`
  - 4 `En_out_mem`, 3 `En_wb_count`, 2 `En_o_count`, 1 `Res_wb_count`, 0 `Res_o_count`
- `In_data`  in  DATA_W  external input sample, signed.
- `W_data`  in  DATA_W  weight ROM read data, signed, valid 1 cycle after `W_rd`.
- `B_data`  in  DATA_W  bias ROM read data, signed, valid 1 cycle after `B_rd`.
- `Wb_count`  out  5  weight/bias counter, returned to the control unit.
- `O_count`  out  3  output-neuron counter.
- `W_rd`, `W_addr`  out  1, 5  weight read strobe and address.
- `B_rd`, `B_addr`  out  1, 3  bias read strobe and address.
- `Out_we`, `Out_addr`, `Out_data`  out  1, 3, DATA_W  output memory write port (all registered).

## Operation
- `Res_reg_all`, `Res_wb_count` and `Res_o_count` are active-low synchronous clears. Each has priority over its enable.
- **Wb_count:**
  - `Res_wb_count`=0 gives 0.
  - Otherwise `En_wb_count`=1 increments it, wrapping 31→0.
  - Otherwise it holds.
- **O_count:** same rules using `Res_o_count`/`En_o_count`, wrapping 7→0.
- **Read strobes (combinational):**
  - `W_rd` = `En_w_mem` & `Res_reg_all`; `W_addr` = `Wb_count`.
  - `B_rd` = `En_b_mem` & `Res_reg_all`; `B_addr` = `O_count`.
- **Pipeline registers:**
  - `mac_v` <= `W_rd`; `a_q` <= `in_reg` when `W_rd`=1.
  - `bias_v` <= `B_rd`.
- **Accumulator sum:** `acc_sum` = `acc` + (`mac_v` ? sext(`a_q`*`W_data`) : 0) + (`bias_v` ? sext(`B_data`) : 0). Signed arithmetic, wraps mod 2^ACC_W.
- **sat():** `acc_sum`<0 gives 0; `acc_sum`>2^(DATA_W-1)-1 gives 2^(DATA_W-1)-1; otherwise `acc_sum`[DATA_W-1:0].
- **Accumulator / write update:**
  - `Res_reg_all`=0: `acc`, `in_reg`, `a_q`, `mac_v`, `bias_v` go to 0; `Out_we` <= 0; any in-flight product or bias is discarded.
  - Else if `En_out_mem`=1: `Out_we` <= 1, `Out_addr` <= `O_count`, `Out_data` <= sat(`acc_sum`), then `acc` <= 0.
  - Else: `acc` <= `acc_sum`; `Out_we` <= 0.
- **Input register:** when `En_input_reg`=1 and `Res_reg_all`=1, `in_reg` <= (`Load_s` ? `In_data` : sat(`acc_sum`)). The `Load_s`=0 path is layer feedback.
- A product or bias landing in the same cycle as `En_out_mem` is included in the written value.

## Timing
- Reset (`Reset`=0) clears everything to 0: all counters, all outputs, `acc`, `in_reg`, `a_q`, `mac_v`, `bias_v`, `Out_data`. `W_rd`/`B_rd` are 0 while `Reset`=0.
- Counters update on the clock edge where enabled; the new value is visible the next cycle.
- Weight/bias latency: strobe in cycle t, data sampled and accumulated at the edge ending t+1, `acc` updated in t+2.
- Write latency: `En_out_mem` in cycle t gives `Out_we`=1 during t+1, a single-cycle pulse per asserted cycle. Back-to-back strobes give back-to-back writes.
- Simultaneous `W_rd` and `B_rd` are legal; both contributions add in the same cycle.
- Reset mid-accumulation: in-flight data is lost. No write occurs in the cycle after reset.

## Test plan
- **Reset:** `Reset`=0 for 2 cycles with `Ctrl`=0x3FF and random inputs → all outputs 0, `W_rd`=`B_rd`=0, `Out_we`=0.
- **Counter wrap and clear:**
  - `Ctrl`=0x10B held for 32 cycles → `Wb_count` runs 0..31 then 0; `O_count` stays 0.
  - Then `Ctrl`=0x109 → `Wb_count`=0 next cycle.
- **MAC:**
  - `Ctrl`=0x383 with `In_data`=3 → `in_reg`=3.
  - Then `Ctrl`=0x143 for 2 cycles, with `W_data`=2 and −5 each one cycle after its strobe → `acc` = 6, then −9; `W_addr` follows `Wb_count`.
- **Bias and write:**
  - From `acc`=−9, `Ctrl`=0x123 with `B_data`=20 one cycle later → `acc`=11.
  - Then `Ctrl`=0x113 → next cycle `Out_we`=1, `Out_addr`=0, `Out_data`=11; `acc`=0 after.
- **Saturation:** build `acc`=300 (3×100) then write → `Out_data`=127; build `acc`=−4 then write → `Out_data`=0.
- **Clear mid-operation:** weight strobe, then `Ctrl`=0x003 in the landing cycle → `acc`=0, no `Out_we`, `Wb_count`/`O_count` unchanged.
